// File: rtl/fft_bitrev_loader.sv
// Radix-2 DIT FFT input stage: loads a frame in bit-reversed order, then drains first-stage pairs.
// Optional FFT_INPUT_SCALE_EN halves each component (arithmetic shift) before storage.
module fft_bitrev_loader #(
  parameter int WIDTH = 32,
  parameter int N     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_A,
  output logic [WIDTH-1:0] out_B,
  output logic [WIDTH-1:0] out_twiddle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam int LOG2N = $clog2(N);
  localparam int HW    = WIDTH / 2;
  localparam int KW    = LOG2N - 1;
  localparam logic [WIDTH-1:0] TWIDDLE = {1'b0, {(HW-1){1'b1}}, {HW{1'b0}}};
  localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
  localparam logic [KW-1:0]    K_LAST  = KW'(N / 2 - 1);
  localparam logic [KW-1:0]    K_ZERO  = '0;
  localparam logic [KW-1:0]    K_ONE   = KW'(1);

  typedef enum logic {S_LOAD = 1'b0, S_DRAIN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [LOG2N-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0] r_out_a, w_out_a_nxt;
  logic [WIDTH-1:0] r_out_b, w_out_b_nxt;
  logic [WIDTH-1:0] r_out_tw, w_out_tw_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_last, w_out_last_nxt;
  logic [WIDTH-1:0] r_mem [N];

  logic             w_in_fire;
  logic             w_out_fire;
  logic [LOG2N-1:0] w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic [KW-1:0]    w_rd_k;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_rd_last;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready    = rst_n && (r_state == S_LOAD);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_wr_addr   = bitrev(r_wr_cnt);

`ifdef FFT_INPUT_SCALE_EN
  assign w_wr_data = {in_data[WIDTH-1], in_data[WIDTH-1:HW+1],
                      in_data[HW-1],    in_data[HW-1:1]};
`else
  assign w_wr_data = in_data;
`endif

  // Pair 0 is loaded on the final write; its slots were filled earlier in the frame.
  assign w_rd_k    = (r_state == S_LOAD) ? K_ZERO : (r_k + K_ONE);
  assign w_rd_a    = r_mem[{w_rd_k, 1'b0}];
  assign w_rd_b    = r_mem[{w_rd_k, 1'b1}];
  assign w_rd_last = (w_rd_k == K_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_k_nxt         = r_k;
    w_out_a_nxt     = r_out_a;
    w_out_b_nxt     = r_out_b;
    w_out_tw_nxt    = r_out_tw;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    case (r_state)
      S_LOAD: begin
        if (w_in_fire) begin
          w_wr_cnt_nxt = r_wr_cnt + LOG2N'(1);
          if (r_wr_cnt == WR_LAST) begin
            w_state_nxt     = S_DRAIN;
            w_k_nxt         = K_ZERO;
            w_out_a_nxt     = w_rd_a;
            w_out_b_nxt     = w_rd_b;
            w_out_tw_nxt    = TWIDDLE;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = w_rd_last;
          end
        end
      end
      S_DRAIN: begin
        if (w_out_fire) begin
          if (r_k == K_LAST) begin
            w_state_nxt     = S_LOAD;
            w_k_nxt         = K_ZERO;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_k_nxt        = r_k + K_ONE;
            w_out_a_nxt    = w_rd_a;
            w_out_b_nxt    = w_rd_b;
            w_out_last_nxt = w_rd_last;
          end
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_wr_cnt    <= '0;
      r_k         <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_tw    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_k         <= w_k_nxt;
      r_out_a     <= w_out_a_nxt;
      r_out_b     <= w_out_b_nxt;
      r_out_tw    <= w_out_tw_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) r_mem[w_wr_addr] <= w_wr_data;
  end

  assign out_A       = r_out_a;
  assign out_B       = r_out_b;
  assign out_twiddle = r_out_tw;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Randomized self-checking bench for fft_bitrev_loader (N=8 and N=16 instances).
module tb_fft_bitrev_loader;
  localparam int W = 32;
  localparam logic [W-1:0] TWID = 32'h7FFF0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [W-1:0] in_data8, a8, b8, tw8;
  logic in_valid8, in_ready8, ov8, or8, last8;
  logic [W-1:0] in_data16, a16, b16, tw16;
  logic in_valid16, in_ready16, ov16, or16, last16;

  int n_cmp = 0;
  int n_err = 0;

  fft_bitrev_loader #(.WIDTH(W), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_A(a8), .out_B(b8), .out_twiddle(tw8), .out_valid(ov8), .out_ready(or8), .out_last(last8));

  fft_bitrev_loader #(.WIDTH(W), .N(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_A(a16), .out_B(b16), .out_twiddle(tw16), .out_valid(ov16), .out_ready(or16), .out_last(last16));

  // Reverse the low 'bits' bits of v using plain arithmetic.
  function automatic int brev(input int v, input int bits);
    int r = 0;
    int x = v;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] mdl_store(input logic [W-1:0] d);
`ifdef FFT_INPUT_SCALE_EN
    int re, im;
    logic [W-1:0] r;
    re = int'($signed(d[31:16]));
    im = int'($signed(d[15:0]));
    re = re >>> 1;
    im = im >>> 1;
    r = {re[15:0], im[15:0]};
    return r;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid8 = 0; in_data8 = '0; or8 = 0;
    in_valid16 = 0; in_data16 = '0; or16 = 0;
    repeat (2) @(negedge clk);
    if (ov8 !== 1'b0)       begin n_err++; $display("FAIL rst_valid: got %b expected 0", ov8); end
    if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready8); end
    if (a8 !== '0)          begin n_err++; $display("FAIL rst_A: got %h expected 0", a8); end
    if (b8 !== '0)          begin n_err++; $display("FAIL rst_B: got %h expected 0", b8); end
    if (tw8 !== '0)         begin n_err++; $display("FAIL rst_tw: got %h expected 0", tw8); end
    if (last8 !== 1'b0)     begin n_err++; $display("FAIL rst_last: got %b expected 0", last8); end
    n_cmp += 6;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready8); end
  endtask

  // dmode: 0 ramp real=i, 1 random, 3 first sample 0x80007FFE. rpat: 0 always ready, 1 {1,0,0,1}, 2 random.
  task automatic run_frame8(input int dmode, input int rpat, input bit hold_valid);
    logic [W-1:0] smp[$];
    logic [W-1:0] mem[8];
    logic [W-1:0] pa, pb, pt, d;
    logic pl, prev_stall, rdy, nv;
    int acc, pk, cyc, last_acc_cyc, rcnt;
    bit finished;
    acc = 0; pk = 0; cyc = 0; last_acc_cyc = -10; rcnt = 0; finished = 0; prev_stall = 0;
    pa = '0; pb = '0; pt = '0; pl = 0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (last_acc_cyc == cyc - 1) begin
        n_cmp++;
        if (ov8 !== 1'b1) begin n_err++; $display("FAIL latency_valid: got %b expected 1", ov8); end
      end
      if (pk == 4) begin
        n_cmp += 3;
        if (ov8 !== 1'b0)       begin n_err++; $display("FAIL extra_pair_valid: got %b expected 0", ov8); end
        if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL turnaround_in_ready: got %b expected 1", in_ready8); end
        if (last8 !== 1'b0)     begin n_err++; $display("FAIL last_after_frame: got %b expected 0", last8); end
        finished = 1;
        in_valid8 = 0; or8 = 0;
      end else begin
        if (ov8 === 1'b1) begin
          if (acc < 8) begin
            n_cmp++; n_err++;
            $display("FAIL early_valid: out_valid=1 after %0d of 8 samples", acc);
          end else begin
            n_cmp++;
            if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL drain_in_ready: got %b expected 0", in_ready8); end
            chk($sformatf("pair%0d_A", pk), a8, mem[2*pk]);
            chk($sformatf("pair%0d_B", pk), b8, mem[2*pk+1]);
            chk("twiddle", tw8, TWID);
            chk($sformatf("pair%0d_last", pk), {31'd0, last8}, {31'd0, (pk == 3)});
            if (dmode == 3 && pk == 0) chk("scaled_A0", a8, 32'hC0003FFF);
            if (prev_stall) begin
              chk("stall_A", a8, pa);
              chk("stall_B", b8, pb);
              chk("stall_tw", tw8, pt);
              chk("stall_last", {31'd0, last8}, {31'd0, pl});
            end
          end
        end
        nv = hold_valid ? 1'b1 : ((dmode == 0 || dmode == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
        if (dmode == 0) d = W'(acc) << 16;
        else if (dmode == 3 && acc == 0) d = 32'h80007FFE;
        else d = $urandom;
        in_valid8 = nv;
        in_data8 = d;
        case (rpat)
          0: rdy = 1'b1;
          1: rdy = (rcnt % 4 == 0) || (rcnt % 4 == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        or8 = rdy;
        if (nv && in_ready8 === 1'b1) begin
          if (acc < 8) begin
            smp.push_back(d);
            acc++;
            if (acc == 8) begin
              for (int i = 0; i < 8; i++) mem[brev(i, 3)] = mdl_store(smp[i]);
              last_acc_cyc = cyc;
            end
          end else begin
            n_cmp++; n_err++;
            $display("FAIL extra_accept: sample accepted beyond 8 in frame");
          end
        end
        if (ov8 === 1'b1) begin
          rcnt++;
          if (rdy) pk++;
        end
        prev_stall = (ov8 === 1'b1) && !rdy;
        pa = a8; pb = b8; pt = tw8; pl = last8;
      end
    end
    if (!finished) begin
      n_cmp++; n_err++;
      $display("FAIL frame_timeout: pairs %0d accepted %0d", pk, acc);
      in_valid8 = 0; or8 = 0;
    end
  endtask

  task automatic test_reset_midframe();
    int acc = 0;
    while (acc < 5) begin
      @(negedge clk);
      in_valid8 = 1; in_data8 = $urandom;
      if (in_ready8 === 1'b1) acc++;
    end
    @(negedge clk);
    in_valid8 = 0;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (ov8 !== 1'b0)       begin n_err++; $display("FAIL midrst_valid: got %b expected 0", ov8); end
    if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready8); end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame8(1, 0, 1'b0);
  endtask

  task automatic test_reset_in_drain();
    int cyc = 0;
    while (cyc < 40 && ov8 !== 1'b1) begin
      @(negedge clk);
      cyc++;
      in_valid8 = 1; in_data8 = $urandom; or8 = 0;
    end
    in_valid8 = 0;
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (cyc >= 40)      begin n_err++; $display("FAIL drain_wait_timeout: out_valid never rose"); end
    if (ov8 !== 1'b0)   begin n_err++; $display("FAIL drainrst_valid: got %b expected 0", ov8); end
    if (last8 !== 1'b0) begin n_err++; $display("FAIL drainrst_last: got %b expected 0", last8); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_n16();
    logic [W-1:0] smp[16];
    logic [W-1:0] mem[16];
    int pk = 0;
    int cyc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready16 !== 1'b1) begin n_err++; $display("FAIL n16_in_ready: got %b expected 1", in_ready16); end
      smp[i] = $urandom;
      in_valid16 = 1; in_data16 = smp[i];
    end
    for (int i = 0; i < 16; i++) mem[brev(i, 4)] = mdl_store(smp[i]);
    @(negedge clk);
    in_valid16 = 0; or16 = 1;
    while (pk < 8 && cyc < 40) begin
      if (ov16 === 1'b1) begin
        chk($sformatf("n16_pair%0d_A", pk), a16, mem[2*pk]);
        chk($sformatf("n16_pair%0d_B", pk), b16, mem[2*pk+1]);
        if (pk == 6) chk("n16_sample3_at_pair6", a16, mdl_store(smp[3]));
        if (pk == 4) chk("n16_sample1_at_pair4", a16, mdl_store(smp[1]));
        pk++;
      end
      @(negedge clk);
      cyc++;
    end
    or16 = 0;
    n_cmp += 2;
    if (pk != 8)        begin n_err++; $display("FAIL n16_pair_count: got %0d expected 8", pk); end
    if (ov16 !== 1'b0)  begin n_err++; $display("FAIL n16_end_valid: got %b expected 0", ov16); end
  endtask

  initial begin
    test_reset();
    run_frame8(0, 0, 1'b0);
    run_frame8(1, 1, 1'b0);
    run_frame8(1, 2, 1'b1);
    run_frame8(1, 0, 1'b1);
    run_frame8(1, 2, 1'b0);
    test_reset_midframe();
    test_reset_in_drain();
    run_frame8(1, 1, 1'b1);
`ifdef FFT_INPUT_SCALE_EN
    run_frame8(3, 0, 1'b0);
`endif
    test_n16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
